// File: rtl/uart_tx_pkg.sv
// uart_tx_pkg: shared state encoding and frame constants for the UART transmitter
package uart_tx_pkg;
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
    localparam int DATA_BITS  = 8;
    localparam int FRAME_BITS = 11;
endpackage

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: free-running bit-period counter with a one-cycle bit_done pulse every BIT_CLKS cycles
module uart_baud_gen #(
    parameter int BIT_CLKS = 434
) (
    input  logic sys_clk,
    input  logic rst_n,
    input  logic clear,
    output logic bit_done
);
    localparam int W = $clog2(BIT_CLKS);
    logic [W-1:0] cnt;
    assign bit_done = cnt == W'(BIT_CLKS - 1);
    always_ff @(posedge sys_clk) begin
        if (!rst_n || clear) cnt <= '0;
        else cnt <= bit_done ? '0 : cnt + 1'b1;
    end
endmodule

// File: rtl/uart_transmitter.sv
// uart_transmitter: 8-bit UART TX with start, LSB-first data, selectable parity and stop bit
module uart_transmitter import uart_tx_pkg::*; #(
    parameter int CLK_FREQ  = 50_000_000,
    parameter int BAUD_RATE = 115200
) (
    input  logic       sys_clk,
    input  logic       rst_n,
    input  logic       tx_enable,
    input  logic       even_odd,
    input  logic [7:0] tx_data_in,
    output logic       busy,
    output logic       serial_out
);
    localparam int BIT_CLKS = CLK_FREQ / BAUD_RATE;
    localparam int IW = $clog2(DATA_BITS);
    if (BIT_CLKS < 2) begin : g_bit_clks_check
        $fatal(1, "BIT_CLKS must be at least 2");
    end
    state_t state, next_state;
    logic [DATA_BITS-1:0] data_q;
    logic parity_q, bit_done, tx_next, busy_next;
    logic [IW-1:0] idx, idx_next;
    uart_baud_gen #(.BIT_CLKS(BIT_CLKS)) u_baud (
        .sys_clk (sys_clk),
        .rst_n   (rst_n),
        .clear   (state == IDLE),
        .bit_done(bit_done)
    );
    always_ff @(posedge sys_clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            serial_out <= 1'b1;
            busy       <= 1'b0;
            idx        <= '0;
            data_q     <= '0;
            parity_q   <= 1'b0;
        end else begin
            state      <= next_state;
            serial_out <= tx_next;
            busy       <= busy_next;
            idx        <= idx_next;
            if (state == IDLE && tx_enable) begin
                data_q   <= tx_data_in;
                parity_q <= even_odd;
            end
        end
    end
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    next_state = tx_enable ? START : IDLE;
            START:   next_state = bit_done ? DATA : START;
            DATA:    next_state = (bit_done && idx == IW'(DATA_BITS - 1)) ? PARITY : DATA;
            PARITY:  next_state = bit_done ? STOP : PARITY;
            STOP:    next_state = bit_done ? IDLE : STOP;
            default: next_state = IDLE;
        endcase
    end
    // Outputs are computed from the upcoming state so the line is driven straight from a flop
    always_comb begin
        idx_next  = state == IDLE ? '0 : (state == DATA && bit_done) ? idx + 1'b1 : idx;
        busy_next = next_state != IDLE;
        tx_next   = next_state == START  ? 1'b0 :
                    next_state == DATA   ? data_q[idx_next] :
                    next_state == PARITY ? (^data_q ^ parity_q) : 1'b1;
    end
endmodule

// File: tb/tb_uart_transmitter.sv
// tb_uart_transmitter: directed checks of framing, parity, input capture, gaps and reset
module tb_uart_transmitter;
    localparam int BIT = 16;
    localparam int FRAME = 11 * BIT;
    logic sys_clk, rst_n, tx_enable, even_odd, busy, serial_out;
    logic [7:0] tx_data_in;
    int tests = 0, fails = 0, busy_cycles = 0;

    uart_transmitter #(.CLK_FREQ(1600), .BAUD_RATE(100)) dut (
        .sys_clk   (sys_clk),
        .rst_n     (rst_n),
        .tx_enable (tx_enable),
        .even_odd  (even_odd),
        .tx_data_in(tx_data_in),
        .busy      (busy),
        .serial_out(serial_out)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge sys_clk);
            check({tag, " line"}, 32'(serial_out), 32'd1);
            check({tag, " busy"}, 32'(busy), 32'd0);
        end
    endtask

    // act: 1 = switch inputs to CC/odd, 2 = drop tx_enable, 3 = assert reset
    task automatic run_frame(input string tag, input logic [10:0] bits, input int ncyc,
                             input int act_cyc, input int act);
        for (int i = 0; i < ncyc; i++) begin
            @(negedge sys_clk);
            check($sformatf("%s line c%0d", tag, i), 32'(serial_out), 32'(bits[i / BIT]));
            check($sformatf("%s busy c%0d", tag, i), 32'(busy), 32'd1);
            if (busy === 1'b1) busy_cycles++;
            if (i == act_cyc) begin
                if (act == 1) begin
                    tx_data_in = 8'hCC;
                    even_odd = 1'b1;
                end
                if (act == 2) tx_enable = 1'b0;
                if (act == 3) rst_n = 1'b0;
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        tx_enable = 1'b1;
        even_odd = 1'b0;
        tx_data_in = 8'hAA;
        check_idle("reset", 2);
        rst_n = 1'b1;
        busy_cycles = 0;
        run_frame("aa_even", {1'b1, 1'b0, 8'hAA, 1'b0}, FRAME, 5 * BIT, 1);
        check_idle("gap", 1);
        check("busy count", 32'(busy_cycles), 32'd176);
        run_frame("cc_odd", {1'b1, 1'b1, 8'hCC, 1'b0}, FRAME, 100, 2);
        check_idle("after cc", 20);
        @(negedge sys_clk);
        tx_enable = 1'b1;
        tx_data_in = 8'h3C;
        even_odd = 1'b0;
        run_frame("pre_rst", {1'b1, 1'b0, 8'h3C, 1'b0}, 4 * BIT + 5, 4 * BIT + 4, 3);
        check_idle("mid rst", 1);
        rst_n = 1'b1;
        tx_enable = 1'b0;
        check_idle("post rst", 1);
        tx_enable = 1'b1;
        run_frame("pulse", {1'b1, 1'b0, 8'h3C, 1'b0}, FRAME, 0, 2);
        check_idle("final idle", 30);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
